control_cmd_watchdog: RTL and testbench



---
 rtl/control_cmd_watchdog.sv | 97 +++++++++
 tb/tb_control_cmd_watchdog.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/control_cmd_watchdog.sv
// Command-stream watchdog: collects a fixed-length signature and, on a match, arms a cycle
// timer whose expiry requests a system reset. Optional macro: WATCHDOG_RESET_HOLD_EN.
module control_cmd_watchdog #(
  parameter int WATCHDOG_SIGNATURE_BITS = 32,
  parameter logic [WATCHDOG_SIGNATURE_BITS-1:0] WATCHDOG_SIGNATURE_PATTERN = 32'hDEADBEEF,
  parameter int WATCHDOG_CONTROL_TICKS = 192,
  parameter int _UNUSED = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       enable,
  output logic       sys_reset,
  output logic       done
);

  localparam int W        = WATCHDOG_SIGNATURE_BITS;
  localparam int SIGBYTES = W / 8;
  localparam int CNT_W    = $clog2(SIGBYTES + 1);
  localparam int TIMER_W  = $clog2(WATCHDOG_CONTROL_TICKS + 1);
  localparam logic [CNT_W-1:0]   LAST_IDX   = CNT_W'(SIGBYTES - 1);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(WATCHDOG_CONTROL_TICKS);
  localparam int unused_placeholder = _UNUSED;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       shift_q, shift_d;
  logic               armed_q, armed_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               sys_reset_q, sys_reset_d;
  logic               done_q, done_d;

  logic [W-1:0] sig_word;
  logic         sig_last;
  logic         sig_match;

  // The word as it will look after this edge, so the final byte is part of the compare.
  assign sig_word  = (shift_q << 8) | W'(data_in);
  assign sig_last  = enable && (cnt_q == LAST_IDX);
  assign sig_match = sig_last && (sig_word == WATCHDOG_SIGNATURE_PATTERN);

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    armed_d = armed_q;
    timer_d = timer_q;
`ifdef WATCHDOG_RESET_HOLD_EN
    sys_reset_d = sys_reset_q;
`else
    sys_reset_d = 1'b0;
`endif

    if (enable) begin
      shift_d = sig_word;
      cnt_d   = sig_last ? '0 : cnt_q + 1'b1;
      done_d  = sig_last;
    end

    if (armed_q) begin
      if (timer_q != '0) begin
        timer_d = timer_q - 1'b1;
      end else begin
        armed_d     = 1'b0;
        sys_reset_d = 1'b1;
      end
    end

    // A refresh landing on the expiry edge takes priority over the reset request.
    if (sig_match) begin
      armed_d     = 1'b1;
      timer_d     = TIMER_LOAD;
      sys_reset_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      shift_q     <= '0;
      armed_q     <= 1'b0;
      timer_q     <= '0;
      sys_reset_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      armed_q     <= armed_d;
      timer_q     <= timer_d;
      sys_reset_q <= sys_reset_d;
      done_q      <= done_d;
    end
  end

  assign sys_reset = sys_reset_q;
  assign done      = done_q;

endmodule

// File: tb/tb_control_cmd_watchdog.sv
// Directed bench for control_cmd_watchdog; expectations follow WATCHDOG_RESET_HOLD_EN when defined.
module tb_control_cmd_watchdog;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       sys_reset;
  logic       done;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int sr_cnt = 0;

  always #5 clk = ~clk;

  control_cmd_watchdog dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .enable    (enable),
    .sys_reset (sys_reset),
    .done      (done)
  );

  initial begin
    #2ms;
    $display("FAIL timeout: observed no finish, expected finish before 2ms");
    $fatal(1, "simulation timeout");
  end

  // All waiting goes through tick so output activity is tallied at every sample point.
  task automatic tick();
    @(negedge clk);
    if (done === 1'b1) done_cnt++;
    if (sys_reset === 1'b1) sr_cnt++;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0b, expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    data_in = b;
    enable  = 1'b1;
    tick();
    enable  = 1'b0;
    data_in = 8'h00;
  endtask

  // Returns on the sample point right after the completion edge.
  task automatic send_sig(input logic [31:0] sig, input int gap);
    done_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) repeat (gap) tick();
      send_byte(sig[31-8*i -: 8]);
    end
    check_int("done_early", done_cnt, 0);
    repeat (gap) tick();
    send_byte(sig[7:0]);
    check_bit("done_set", done, 1'b1);
  endtask

  task automatic wait_sysrst(input string tag, input int exp_n);
    int n;
    for (n = 1; n <= 600; n++) begin
      tick();
      if (n == 1) check_bit({tag, "_done_clr"}, done, 1'b0);
      if (sys_reset === 1'b1) break;
    end
    check_int(tag, n, exp_n);
  endtask

  task automatic apply_reset(input string tag);
    reset = 1'b0;
    tick();
    tick();
    check_bit({tag, "_done"}, done, 1'b0);
    check_bit({tag, "_sysrst"}, sys_reset, 1'b0);
    reset = 1'b1;
  endtask

  task automatic check_release(input string tag);
`ifdef WATCHDOG_RESET_HOLD_EN
    sr_cnt = 0;
    repeat (400) tick();
    check_int({tag, "_hold"}, sr_cnt, 400);
    reset = 1'b0;
    #1;
    check_bit({tag, "_hold_clr"}, sys_reset, 1'b0);
    tick();
    reset = 1'b1;
`else
    tick();
    check_bit({tag, "_pulse_end"}, sys_reset, 1'b0);
    sr_cnt = 0;
    repeat (50) tick();
    check_int({tag, "_quiet"}, sr_cnt, 0);
`endif
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) tick();
    check_bit("rst_done", done, 1'b0);
    check_bit("rst_sysrst", sys_reset, 1'b0);
    reset = 1'b1;

    done_cnt = 0;
    sr_cnt = 0;
    repeat (1000) tick();
    check_int("idle_done", done_cnt, 0);
    check_int("idle_sysrst", sr_cnt, 0);

    // Basic: one strobe every 16 cycles, expiry 193 cycles after done.
    sr_cnt = 0;
    send_sig(32'hDEADBEEF, 15);
    check_int("basic_no_early_sr", sr_cnt, 0);
    wait_sysrst("basic_expiry", 193);
    check_release("basic");

    // Mismatch: done pulses, timer stays disarmed.
    send_sig(32'hDEADBEEE, 15);
    done_cnt = 0;
    sr_cnt = 0;
    repeat (1000) tick();
    check_int("mm_done_once", done_cnt, 0);
    check_int("mm_no_sysrst", sr_cnt, 0);

    // Refresh 100 cycles after the first done.
    sr_cnt = 0;
    send_sig(32'hDEADBEEF, 0);
    repeat (96) tick();
    send_sig(32'hDEADBEEF, 0);
    check_int("refresh_no_sr", sr_cnt, 0);
    wait_sysrst("refresh_expiry", 193);
    check_release("refresh");

    // Refresh completing on the exact expiry edge wins.
    sr_cnt = 0;
    send_sig(32'hDEADBEEF, 0);
    repeat (189) tick();
    send_sig(32'hDEADBEEF, 0);
    check_bit("tie_no_sr_now", sys_reset, 1'b0);
    check_int("tie_no_sr_before", sr_cnt, 0);
    wait_sysrst("tie_expiry", 193);
    check_release("tie");

    // Reset after two bytes discards the partial signature.
    send_byte(8'hDE);
    repeat (15) tick();
    send_byte(8'hAD);
    apply_reset("mid_rst");
    send_sig(32'hDEADBEEF, 15);
    wait_sysrst("mid_rst_expiry", 193);
    check_release("mid_rst");

`ifdef WATCHDOG_RESET_HOLD_EN
    send_sig(32'hDEADBEEF, 0);
    wait_sysrst("hold_match_expiry", 193);
    repeat (30) tick();
    check_bit("hold_still_high", sys_reset, 1'b1);
    send_sig(32'hDEADBEEF, 0);
    check_bit("hold_clr_by_match", sys_reset, 1'b0);
    apply_reset("hold_end");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
